mux_stream_nx: RTL

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshaking. It supersedes the combinational 2:1 byte mux in the datapath. It adds a registered output stage, backpressure, an output channel tag, and a runtime-selectable mode: manual select or round-robin arbitration. It sits between per-source data producers (ALU, RAM read port, I/O registers) and a single downstream consumer.

---
 rtl/mux_stream_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/mux_stream_nx.sv | 93 +++++++++
 3 files changed

// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: shared mode encodings and width helper for the stream multiplexer
// Contents:
//   clog2       - ceiling log2 used to size select/tag fields
//   MODE_MANUAL - grant follows the sel input
//   MODE_RR     - grant follows round-robin arbitration
package mux_stream_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter built as rotate, priority-encode, un-rotate
// Ports:
//   req         in  N     request vector
//   ptr         in  SELW  highest-priority index (must be < N)
//   enable      in  1     gates grant_valid
//   grant_valid out 1     some request is granted
//   grant_idx   out SELW  index of the granted request
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            enable,
    output logic            grant_valid,
    output logic [SELW-1:0] grant_idx
);

    logic [N-1:0] rot;
    int           first;

    always_comb begin
        rot = '0;
        // rot[j] = req[(ptr + j) mod N]; constant indices only, so any N works
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if (i == (int'(ptr) + j) % N) rot[j] = req[i];
        first = 0;
        grant_valid = 1'b0;
        for (int j = N - 1; j >= 0; j--)
            if (rot[j]) begin
                first = j;
                grant_valid = enable;
            end
        grant_idx = SELW'((int'(ptr) + first) % N);
    end

endmodule

// File: rtl/mux_stream_nx.sv
// mux_stream_nx: N-channel registered stream mux with manual or round-robin selection
// Ports:
//   clk, reset  in   clock, synchronous active-high reset
//   in_data     in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid    in   N        per-channel valid
//   in_ready    out  N        per-channel ready (combinational, one-hot or zero)
//   sel         in   SELW     channel used in manual mode
//   mode        in   1        MODE_MANUAL / MODE_RR
//   out_data    out  WIDTH    registered word
//   out_chan    out  SELW     channel that produced out_data
//   out_valid   out  1        output register holds a word
//   out_ready   in   1        consumer accepts the word
module mux_stream_nx
    import mux_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load, man_valid, rr_valid, grant_valid, xfer;
    logic [SELW-1:0]  rr_idx, grant_idx;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
        .req        (in_valid),
        .ptr        (ptr_q),
        .enable     (mode == MODE_RR),
        .grant_valid(rr_valid),
        .grant_idx  (rr_idx)
    );

    always_comb begin
        load = !out_valid_q || out_ready;
        // sel values >= N match no channel and therefore never grant
        man_valid = 1'b0;
        for (int i = 0; i < N; i++)
            if (sel == SELW'(i)) man_valid = in_valid[i];
        grant_valid = (mode == MODE_RR) ? rr_valid : man_valid;
        grant_idx   = (mode == MODE_RR) ? rr_idx : sel;
        xfer = load && grant_valid && !reset;
        in_ready = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++)
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = xfer;
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        out_valid_d = load ? grant_valid : out_valid_q;
        out_data_d  = xfer ? grant_data : out_data_q;
        out_chan_d  = xfer ? grant_idx : out_chan_q;
        // explicit wrap keeps ptr < N when N is not a power of two
        ptr_d = (xfer && mode == MODE_RR)
              ? ((grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1))
              : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule
